// File: rtl/clk_en_gen_pkg.sv
// Shared types and helpers for the clk_en_gen fractional clock-enable generator.
package clk_en_gen_pkg;

  localparam int DEF_ACC_W = 32;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Increment giving f_out_hz strobes from f_ref_hz, rounded to nearest.
  function automatic logic [DEF_ACC_W-1:0] inc_from_freq(input longint unsigned f_ref_hz,
                                                         input longint unsigned f_out_hz);
    longint unsigned scaled;
    scaled = ((f_out_hz << DEF_ACC_W) + (f_ref_hz >> 1)) / f_ref_hz;
    return scaled[DEF_ACC_W-1:0];
  endfunction

endpackage

// File: rtl/clk_en_gen_acc.sv
// Single-channel phase accumulator: one-cycle strobe on carry-out plus a
// toggle output; load replaces phase and increment and clears the toggle.
module clk_en_acc #(
  parameter int               ACC_W    = 32,
  parameter logic [ACC_W-1:0] INIT_INC = {1'b1, {(ACC_W-1){1'b0}}}
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             ch_en,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic [ACC_W-1:0] load_phase,
  output logic             strobe,
  output logic             tgl
);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] inc_reg;
  logic             strobe_reg;
  logic             tgl_reg;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc_reg} + {1'b0, inc_reg};

  always_ff @(posedge refclk) begin
    if (rst) begin
      acc_reg    <= '0;
      inc_reg    <= INIT_INC;
      strobe_reg <= 1'b0;
      tgl_reg    <= 1'b0;
    end else begin
      // The strobe on a load edge still comes from the old phase/increment.
      strobe_reg <= ch_en & sum[ACC_W];
      if (load) begin
        acc_reg <= load_phase;
        inc_reg <= load_inc;
        tgl_reg <= 1'b0;
      end else if (ch_en) begin
        acc_reg <= sum[ACC_W-1:0];
        if (sum[ACC_W]) begin
          tgl_reg <= ~tgl_reg;
        end
      end
    end
  end

  assign strobe = strobe_reg;
  assign tgl    = tgl_reg;

endmodule

// File: rtl/clk_en_gen.sv
// N-channel clock-enable generator with reconfig handshake and settle/lock sequencer.
// Optional per-channel strobe counters are enabled by defining CLK_EN_GEN_CNT_EN.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int                      NUM_CH        = 2,
  parameter int                      ACC_W         = DEF_ACC_W,
  parameter int                      SETTLE_CYCLES = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] INIT_INC      = {NUM_CH{inc_from_freq(64'd2, 64'd1)}},
  localparam int                     CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] outclk_en,
  output logic [NUM_CH-1:0] outclk_tgl,
  output logic [NUM_CH-1:0] ch_rst,
  output logic              locked
`ifdef CLK_EN_GEN_CNT_EN
  ,
  output logic [NUM_CH*16-1:0] strobe_cnt
`endif
);

  localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CH_W:0]   NUM_CH_L = (CH_W + 1)'(NUM_CH);

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                locked_reg;
  logic                cfg_ready_reg;
  logic [NUM_CH-1:0]   ch_rst_reg;
  logic                cfg_accept;
  logic                cfg_in_range;
  logic [NUM_CH-1:0]   load;

  assign cfg_accept   = cfg_valid & cfg_ready_reg;
  assign cfg_in_range = ({1'b0, cfg_ch} < NUM_CH_L);

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg     <= SETTLE;
      cnt_reg       <= CNT_INIT;
      locked_reg    <= 1'b0;
      cfg_ready_reg <= 1'b0;
      ch_rst_reg    <= '1;
    end else begin
      case (state_reg)
        SETTLE: begin
          if (cnt_reg == '0) begin
            state_reg     <= LOCKED;
            locked_reg    <= 1'b1;
            cfg_ready_reg <= 1'b1;
            ch_rst_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        LOCKED: begin
          // Out-of-range channel requests complete the handshake but change nothing.
          if (cfg_accept && cfg_in_range) begin
            state_reg     <= SETTLE;
            cnt_reg       <= CNT_INIT;
            locked_reg    <= 1'b0;
            cfg_ready_reg <= 1'b0;
            ch_rst_reg    <= ch_rst_reg | load;
          end
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_reg;
  assign locked    = locked_reg;
  assign ch_rst    = ch_rst_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign load[gi] = cfg_accept & cfg_in_range & (cfg_ch == CH_W'(gi));

    clk_en_acc #(
      .ACC_W    (ACC_W),
      .INIT_INC (INIT_INC[gi*ACC_W +: ACC_W])
    ) u_acc (
      .refclk     (refclk),
      .rst        (rst),
      .ch_en      (ch_en[gi]),
      .load       (load[gi]),
      .load_inc   (cfg_inc),
      .load_phase (cfg_phase),
      .strobe     (outclk_en[gi]),
      .tgl        (outclk_tgl[gi])
    );
  end

`ifdef CLK_EN_GEN_CNT_EN
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
    logic [15:0] strobe_cnt_reg;

    always_ff @(posedge refclk) begin
      if (rst || load[gi]) begin
        strobe_cnt_reg <= '0;
      end else if (outclk_en[gi]) begin
        strobe_cnt_reg <= strobe_cnt_reg + 16'd1;
      end
    end

    assign strobe_cnt[gi*16 +: 16] = strobe_cnt_reg;
  end
`else
  // Without the counter option the strobes themselves are the only rate outputs.
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen. Three channels are used so that cfg_ch=3 is
// representable on the 2-bit channel select and exercises the out-of-range path.
module tb_clk_en_gen;
  import clk_en_gen_pkg::*;

  logic        refclk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_inc;
  logic [31:0] cfg_phase;
  logic [2:0]  ch_en;
  logic [2:0]  outclk_en;
  logic [2:0]  outclk_tgl;
  logic [2:0]  ch_rst;
  logic        locked;
`ifdef CLK_EN_GEN_CNT_EN
  logic [47:0] strobe_cnt;
`endif

  clk_en_gen #(
    .NUM_CH        (3),
    .ACC_W         (32),
    .SETTLE_CYCLES (16),
    .INIT_INC      ({3{32'h8000_0000}})
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_inc    (cfg_inc),
    .cfg_phase  (cfg_phase),
    .ch_en      (ch_en),
    .outclk_en  (outclk_en),
    .outclk_tgl (outclk_tgl),
    .ch_rst     (ch_rst),
    .locked     (locked)
`ifdef CLK_EN_GEN_CNT_EN
    ,
    .strobe_cnt (strobe_cnt)
`endif
  );

  always #5 refclk = ~refclk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic [2:0] en;
    logic [2:0] tgl;
    logic       lck;
    logic [2:0] crst;
    logic       rdy;
  } rst_vec_t;

  rst_vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge refclk);
  endtask

  // Drives one request and returns at the negedge after the handshake edge.
  task automatic request(input logic [1:0] ch, input logic [31:0] inc, input logic [31:0] ph);
    int n;
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_inc   = inc;
    cfg_phase = ph;
    n = 0;
    while (!cfg_ready && n < 64) begin
      cyc();
      n++;
    end
    chk($sformatf("ready_for_req_ch%0d", ch), 64'(cfg_ready), 64'd1);
    cyc();
    cfg_valid = 1'b0;
    $display("req ch=%0d inc=0x%08h phase=0x%08h accepted", ch, inc, ph);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    int n;
    longint unsigned exp_cnt;
    int strobes;
    logic [1:0] res_en[4];
    logic [1:0] res_tgl[4];

    // Post-reset samples: inc=2^31 gives a strobe on every even edge.
    tbl[0] = '{1,  3'b000, 3'b000, 1'b0, 3'b111, 1'b0};
    tbl[1] = '{2,  3'b111, 3'b111, 1'b0, 3'b111, 1'b0};
    tbl[2] = '{3,  3'b000, 3'b111, 1'b0, 3'b111, 1'b0};
    tbl[3] = '{4,  3'b111, 3'b000, 1'b0, 3'b111, 1'b0};
    tbl[4] = '{5,  3'b000, 3'b000, 1'b0, 3'b111, 1'b0};
    tbl[5] = '{14, 3'b111, 3'b111, 1'b0, 3'b111, 1'b0};
    tbl[6] = '{15, 3'b000, 3'b111, 1'b0, 3'b111, 1'b0};
    tbl[7] = '{16, 3'b111, 3'b000, 1'b1, 3'b000, 1'b1};
    tbl[8] = '{17, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1};

    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_inc = '0;
    cfg_phase = '0;
    ch_en = 3'b111;
    repeat (3) cyc();
    chk("rst_outclk_en", 64'(outclk_en), 64'd0);
    chk("rst_outclk_tgl", 64'(outclk_tgl), 64'd0);
    chk("rst_ch_rst", 64'(ch_rst), 64'h7);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    rst = 1'b0;

    cur = 0;
    for (int i = 0; i < 9; i++) begin
      while (cur < tbl[i].cyc) begin
        cyc();
        cur++;
      end
      chk($sformatf("boot%0d_en", cur), 64'(outclk_en), 64'(tbl[i].en));
      chk($sformatf("boot%0d_tgl", cur), 64'(outclk_tgl), 64'(tbl[i].tgl));
      chk($sformatf("boot%0d_locked", cur), 64'(locked), 64'(tbl[i].lck));
      chk($sformatf("boot%0d_ch_rst", cur), 64'(ch_rst), 64'(tbl[i].crst));
      chk($sformatf("boot%0d_ready", cur), 64'(cfg_ready), 64'(tbl[i].rdy));
      $display("boot cycle %0d en=%b tgl=%b locked=%b ch_rst=%b", cur, outclk_en, outclk_tgl,
               locked, ch_rst);
    end

    // Reconfig ch1 to quarter rate; handshake lands on absolute edge 18.
    request(2'd1, inc_from_freq(64'd4, 64'd1), 32'h0);
    chk("rcfg_ready_drop", 64'(cfg_ready), 64'd0);
    chk("rcfg_locked_drop", 64'(locked), 64'd0);
    chk("rcfg_ch_rst", 64'(ch_rst), 64'h2);
    chk("rcfg_old_strobe", 64'(outclk_en), 64'h7);
    chk("rcfg_tgl", 64'(outclk_tgl), 64'h5);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk($sformatf("q%0d_en1", k), 64'(outclk_en[1]), 64'(k % 4 == 0));
      chk($sformatf("q%0d_en0", k), 64'(outclk_en[0]), 64'(k % 2 == 0));
      chk($sformatf("q%0d_tgl1", k), 64'(outclk_tgl[1]), 64'((k / 4) % 2));
      chk($sformatf("q%0d_ch_rst", k), 64'(ch_rst), (k < 16) ? 64'h2 : 64'h0);
      chk($sformatf("q%0d_locked", k), 64'(locked), 64'(k == 16));
    end

    // Out-of-range channel: handshake completes, nothing changes.
    request(2'd3, 32'h0, 32'h0);
    chk("bad_ch_locked", 64'(locked), 64'd1);
    chk("bad_ch_ready", 64'(cfg_ready), 64'd1);
    chk("bad_ch_ch_rst", 64'(ch_rst), 64'h0);
    for (int k = 17; k <= 20; k++) begin
      if (k > 17) cyc();
      chk($sformatf("bad%0d_en0", k), 64'(outclk_en[0]), 64'(k % 2 == 0));
      chk($sformatf("bad%0d_en1", k), 64'(outclk_en[1]), 64'(k % 4 == 0));
    end

    // Freeze ch0 and ch1 for 10 cycles at absolute edge 38 (both accumulators at 0).
    ch_en = 3'b100;
    for (int j = 1; j <= 10; j++) begin
      cyc();
      chk($sformatf("frz%0d_en", j), 64'(outclk_en[1:0]), 64'd0);
      chk($sformatf("frz%0d_tgl", j), 64'(outclk_tgl[1:0]), 64'h3);
      chk($sformatf("frz%0d_en2", j), 64'(outclk_en[2]), 64'((38 + j) % 2 == 0));
    end
    ch_en = 3'b111;
    res_en  = '{2'b00, 2'b01, 2'b00, 2'b11};
    res_tgl = '{2'b11, 2'b10, 2'b10, 2'b01};
    for (int r = 0; r < 4; r++) begin
      cyc();
      chk($sformatf("resume%0d_en", r + 1), 64'(outclk_en[1:0]), 64'(res_en[r]));
      chk($sformatf("resume%0d_tgl", r + 1), 64'(outclk_tgl[1:0]), 64'(res_tgl[r]));
      $display("resume cycle %0d en=%b tgl=%b", r + 1, outclk_en, outclk_tgl);
    end

    // Fractional rate: strobes over N cycles from phase 0 = floor(N*inc/2^32).
    request(2'd1, 32'h80E5_A6E2, 32'h0);
    strobes = 0;
    for (int c = 0; c < 20000; c++) begin
      cyc();
      if (outclk_en[1]) strobes++;
    end
    exp_cnt = (64'd20000 * 64'h80E5_A6E2) >> 32;
    checks++;
    if (longint'(strobes) < longint'(exp_cnt) - 1 || longint'(strobes) > longint'(exp_cnt) + 1) begin
      errors++;
      $display("FAIL freq_strobes: got %0d, want %0d +/-1", strobes, exp_cnt);
    end
    $display("freq test strobes=%0d expected=%0d", strobes, exp_cnt);

    // A request held valid through a settle waits for cfg_ready.
    request(2'd2, inc_from_freq(64'd4, 64'd1), 32'h0);
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_inc   = inc_from_freq(64'd4, 64'd1);
    cfg_phase = 32'h1234_5678;
    n = 0;
    while (!cfg_ready && n < 64) begin
      cyc();
      n++;
    end
    chk("held_req_wait", 64'(n), 64'd16);
    cyc();
    cfg_valid = 1'b0;
    chk("held_req_ch_rst", 64'(ch_rst), 64'h1);
    chk("held_req_locked", 64'(locked), 64'd0);

    // Reset 5 cycles into that settle restores everything, including INIT_INC.
    repeat (4) cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_en", 64'(outclk_en), 64'd0);
    chk("midrst_tgl", 64'(outclk_tgl), 64'd0);
    chk("midrst_ch_rst", 64'(ch_rst), 64'h7);
    chk("midrst_locked", 64'(locked), 64'd0);
    chk("midrst_ready", 64'(cfg_ready), 64'd0);
    rst = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      cyc();
      chk($sformatf("post_rst%0d_en", r), 64'(outclk_en), (r % 2 == 0) ? 64'h7 : 64'h0);
    end
    n = 4;
    while (!locked && n < 64) begin
      cyc();
      n++;
    end
    chk("relock_cycles", 64'(n), 64'd16);
    chk("relock_ch_rst", 64'(ch_rst), 64'h0);
    $display("relock after %0d cycles", n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
